ir_nec_transmitter: RTL and testbench
=====================================

// Module: ir_nec_transmitter
// PURPOSE
//  NEC-format IR transmitter, the send-side counterpart of the board's IR receiver.
//  On a start request it latches a 16-bit custom code and an 8-bit key code.
//  It then emits one frame: lead mark, lead space, 32 data bits and a stop mark.
//  Drives a baseband line (idle high, mark low), which can loop back directly into the receiver.
//  Also drives a 38 kHz carrier-modulated LED output for a real IR emitter.
// PARAMETERS
//  LEAD_MARK_CYC   450000   lead mark length (9 ms @ 50 MHz)
//  LEAD_SPACE_CYC  225000   lead space length (4.5 ms)
//  BIT_MARK_CYC    28000    data/stop mark length (560 us)
//  ZERO_SPACE_CYC  28000    space length for logic 0 (560 us)
//  ONE_SPACE_CYC   84500    space length for logic 1 (1.69 ms)
//  GAP_CYC         2000000  idle guard after stop mark, before busy drops (40 ms)
//  CARRIER_HALF    658      carrier half-period in cycles (~38 kHz)
// PORTS
//  clk          in   1   50 MHz system clock
//  rst_n        in   1   asynchronous active-low reset
//  tx_start     in   1   request a frame; sampled only when tx_busy=0
//  tx_custom    in   16  custom (address) code, e.g. 16'h6B86
//  tx_data      in   8   key code; ~tx_data is generated internally
//  tx_busy      out  1   high from the cycle after accept until the cycle tx_done pulses
//  tx_done      out  1   1-cycle pulse when the guard gap ends
//  ir_base      out  1   baseband frame: 1 = space/idle, 0 = mark
//  ir_led       out  1   carrier output: toggles at CARRIER_HALF during marks, 0 otherwise
// BEHAVIOUR
//  Clock and reset
//   - Clock is clk. Reset is rst_n, asynchronous, active-low.
//   - Reset values: ir_base=1, ir_led=0, tx_busy=0, tx_done=0, state=IDLE, all counters 0.
//   - Reset asserted mid-frame aborts immediately: outputs take reset values, no tx_done pulse.
//  Frame timing
//   - 22-bit segment counter. Each segment lasts exactly its parameter count of cycles.
//   - Segment ends when counter == PARAM-1; counter then clears and the next state is entered.
//  State machine
//   - IDLE: when tx_start=1, latch frame = {~tx_data, tx_data, tx_custom}, go to LEAD_MARK.
//     The frame is transmitted LSB first, and tx_start is accepted on the same edge.
//   - LEAD_MARK (ir_base=0) -> LEAD_SPACE (ir_base=1) -> BIT_MARK.
//   - BIT_MARK (0, BIT_MARK_CYC) -> BIT_SPACE (1).
//   - BIT_SPACE lasts ONE_SPACE_CYC if frame[0]=1, else ZERO_SPACE_CYC.
//     At its end: shift frame right by 1, bit_cnt+1.
//     If bit_cnt was 31 -> STOP_MARK, else -> BIT_MARK.
//   - STOP_MARK (0, BIT_MARK_CYC): terminates the last space for the receiver -> GAP.
//   - GAP (1, GAP_CYC): at its end, tx_done=1 for 1 cycle, tx_busy=0, -> IDLE.
//  Bit order and latency
//   - Bit order on air: custom[0..15], data[0..7], ~data[0..7].
//   - Latency: ir_base falls on the edge after the accept edge, i.e. 1 cycle after tx_start is seen.
//   - Total frame time = 9+4.5 ms + sum of bits + 0.56 ms stop mark + gap.
//  Handshake
//   - tx_start while tx_busy=1 is ignored; it is not queued.
//   - tx_custom/tx_data may change freely after accept.
//   - tx_start held high continuously produces back-to-back frames.
//     Each new frame is accepted in the IDLE cycle following tx_done.
//  Carrier
//   - The carrier counter and phase reset at entry to every mark, so ir_led=1 in the first mark cycle.
//   - ir_led toggles every CARRIER_HALF cycles while ir_base=0, and is forced 0 while ir_base=1.
//   - All outputs are registered (glitch-free).
// TESTING
//  1. tx_custom=16'h6B86, tx_data=8'h45, pulse tx_start; ir_base looped into the IR receiver.
//     -> receiver captured_code=8'h45; tx_done pulses exactly once.
//  2. Measure ir_base low/high widths in test 1.
//     -> 450000 / 225000 cycles, then 32 marks of 28000.
//     -> Spaces 84500 for 1-bits, 28000 for 0-bits; first space matches custom[0]=0 (28000).
//  3. tx_custom=16'h0000, tx_data=8'h00, then 16'hFFFF, 8'hFF.
//     -> Data spaces: 24 short + 8 long, then 24 long + 8 short; stop mark of 28000 present in both.
//  4. Pulse tx_start again 1000 cycles after accept.
//     -> Ignored: only one frame, tx_busy stays high, latched data unchanged.
//  5. Assert rst_n=0 during bit 10 for 3 cycles, then release.
//     -> ir_base=1, ir_led=0, tx_busy=0 immediately; no tx_done; a new tx_start sends a full frame.
//  6. In lead mark, count ir_led edges.
//     -> First cycle high; period 1316 cycles; ir_led=0 throughout every space and the gap.

Source files
------------

// File: rtl/ir_nec_transmitter.sv
// NEC IR frame transmitter: lead mark/space, 32 LSB-first data bits, stop mark, guard gap.
// Drives a baseband line (idle high, mark low) and a carrier-modulated LED output.
module ir_nec_transmitter #(
    parameter int unsigned LEAD_MARK_CYC  = 450000,
    parameter int unsigned LEAD_SPACE_CYC = 225000,
    parameter int unsigned BIT_MARK_CYC   = 28000,
    parameter int unsigned ZERO_SPACE_CYC = 28000,
    parameter int unsigned ONE_SPACE_CYC  = 84500,
    parameter int unsigned GAP_CYC        = 2000000,
    parameter int unsigned CARRIER_HALF   = 658
) (
    input  logic        clk,
    input  logic        rst_n,
    // Handshake: tx_start is taken on any edge where tx_busy=0; while busy it is ignored.
    input  logic        tx_start,
    input  logic [15:0] tx_custom,
    input  logic [7:0]  tx_data,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        ir_base,
    output logic        ir_led,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LEAD_MARK  = 3'd1,
        LEAD_SPACE = 3'd2,
        BIT_MARK   = 3'd3,
        BIT_SPACE  = 3'd4,
        STOP_MARK  = 3'd5,
        GAP        = 3'd6
    } state_e;

    state_e      state_q;
    logic [21:0] seg_cnt_q;
    logic [4:0]  bit_cnt_q;
    logic [31:0] frame_q;
    logic [15:0] car_cnt_q;
    logic        tx_busy_q;
    logic        tx_done_q;
    logic        ir_base_q;
    logic        ir_led_q;

    logic [21:0] seg_len_d;
    logic        seg_last_d;
    logic        is_mark_d;

    always_comb begin
        seg_len_d = 22'd1;
        unique case (state_q)
            LEAD_MARK:  seg_len_d = 22'(LEAD_MARK_CYC);
            LEAD_SPACE: seg_len_d = 22'(LEAD_SPACE_CYC);
            BIT_MARK:   seg_len_d = 22'(BIT_MARK_CYC);
            BIT_SPACE:  seg_len_d = frame_q[0] ? 22'(ONE_SPACE_CYC) : 22'(ZERO_SPACE_CYC);
            STOP_MARK:  seg_len_d = 22'(BIT_MARK_CYC);
            GAP:        seg_len_d = 22'(GAP_CYC);
            default:    seg_len_d = 22'd1;
        endcase
        seg_last_d = (seg_cnt_q == seg_len_d - 22'd1);
        is_mark_d  = (state_q == LEAD_MARK) || (state_q == BIT_MARK) || (state_q == STOP_MARK);
    end

    // Outputs are registered from the current state, so the line lags the state by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            seg_cnt_q <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            car_cnt_q <= '0;
            tx_busy_q <= 1'b0;
            tx_done_q <= 1'b0;
            ir_base_q <= 1'b1;
            ir_led_q  <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            ir_base_q <= ~is_mark_d;

            // Carrier phase restarts at the first cycle of every mark.
            if (is_mark_d) begin
                if (seg_cnt_q == 22'd0) begin
                    ir_led_q  <= 1'b1;
                    car_cnt_q <= '0;
                end else if (car_cnt_q == 16'(CARRIER_HALF - 1)) begin
                    ir_led_q  <= ~ir_led_q;
                    car_cnt_q <= '0;
                end else begin
                    car_cnt_q <= car_cnt_q + 16'd1;
                end
            end else begin
                ir_led_q  <= 1'b0;
                car_cnt_q <= '0;
            end

            if (state_q == IDLE) begin
                if (tx_start) begin
                    frame_q   <= {~tx_data, tx_data, tx_custom};
                    seg_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    tx_busy_q <= 1'b1;
                    state_q   <= LEAD_MARK;
                end
            end else if (!seg_last_d) begin
                seg_cnt_q <= seg_cnt_q + 22'd1;
            end else begin
                seg_cnt_q <= '0;
                unique case (state_q)
                    LEAD_MARK:  state_q <= LEAD_SPACE;
                    LEAD_SPACE: state_q <= BIT_MARK;
                    BIT_MARK:   state_q <= BIT_SPACE;
                    BIT_SPACE: begin
                        frame_q   <= {1'b0, frame_q[31:1]};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        state_q   <= (bit_cnt_q == 5'd31) ? STOP_MARK : BIT_MARK;
                    end
                    STOP_MARK:  state_q <= GAP;
                    GAP: begin
                        tx_done_q <= 1'b1;
                        tx_busy_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                    default:    state_q <= IDLE;
                endcase
            end
        end
    end

    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;
    assign ir_base     = ir_base_q;
    assign ir_led      = ir_led_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Bench for ir_nec_transmitter with shortened segment lengths; each frame is compared
// cycle by cycle against a waveform built from the NEC segment list.
module tb_ir_nec_transmitter;

    localparam int LEAD_MARK  = 40;
    localparam int LEAD_SPACE = 20;
    localparam int BIT_MARK   = 5;
    localparam int ZERO_SPACE = 7;
    localparam int ONE_SPACE  = 15;
    localparam int GAP_LEN    = 30;
    localparam int HALF       = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [15:0] tx_custom = '0;
    logic [7:0]  tx_data = '0;
    logic        tx_busy, tx_done, ir_base, ir_led;
    logic [2:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    bit ok;

    // Expected {ir_base, ir_led} per cycle, starting one cycle after accept.
    logic [1:0] exp_q[$];

    ir_nec_transmitter #(
        .LEAD_MARK_CYC (LEAD_MARK),
        .LEAD_SPACE_CYC(LEAD_SPACE),
        .BIT_MARK_CYC  (BIT_MARK),
        .ZERO_SPACE_CYC(ZERO_SPACE),
        .ONE_SPACE_CYC (ONE_SPACE),
        .GAP_CYC       (GAP_LEN),
        .CARRIER_HALF  (HALF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_start   (tx_start),
        .tx_custom  (tx_custom),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .ir_base    (ir_base),
        .ir_led     (ir_led),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            ok = 1'b0;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void add_seg(input bit level, input int len);
        for (int j = 0; j < len; j++)
            exp_q.push_back({level, (level == 1'b0) && (((j / HALF) % 2) == 0)});
    endfunction

    function automatic void build_model(input logic [15:0] c, input logic [7:0] d);
        logic [31:0] bits;
        bits = {~d, d, c};
        exp_q.delete();
        add_seg(1'b0, LEAD_MARK);
        add_seg(1'b1, LEAD_SPACE);
        for (int i = 0; i < 32; i++) begin
            add_seg(1'b0, BIT_MARK);
            add_seg(1'b1, bits[i] ? ONE_SPACE : ZERO_SPACE);
        end
        add_seg(1'b0, BIT_MARK);
        add_seg(1'b1, GAP_LEN);
    endfunction

    // Called at a negedge with the DUT idle. abort_at >= 0 stops after that cycle index.
    task automatic run_frame(input logic [15:0] c, input logic [7:0] d, input bit keep_start,
                             input bit poke, input int abort_at);
        int total;
        logic [3:0] exp_v;
        build_model(c, d);
        total = exp_q.size();
        tx_custom = c;
        tx_data   = d;
        tx_start  = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_start) tx_start = 1'b0;
        tx_custom = 16'($urandom);
        tx_data   = 8'($urandom);
        ok = 1'b1;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            if (poke && k == 50) tx_start = 1'b1;
            if (poke && k == 52) tx_start = 1'b0;
            exp_v[3]   = (k < total);
            exp_v[2]   = (k == total);
            exp_v[1:0] = (k == 0) ? 2'b10 : exp_q[k-1];
            if (ok) check($sformatf("frame %h/%h cyc %0d {busy,done,base,led}", c, d, k),
                          {28'd0, tx_busy, tx_done, ir_base, ir_led}, {28'd0, exp_v});
            if (k == abort_at) break;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle busy", {31'd0, tx_busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] rc;
        logic [7:0]  rd;
        int stop_k;
        logic [31:0] bits;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset outputs {busy,done,base,led}", {28'd0, tx_busy, tx_done, ir_base, ir_led}, 32'h2);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle outputs", {28'd0, tx_busy, tx_done, ir_base, ir_led}, 32'h2);
        end

        // Reference frame, with an ignored tx_start pulse while busy
        run_frame(16'h6B86, 8'h45, 1'b0, 1'b1, -1);
        @(negedge clk);
        check("single frame: no second accept", {31'd0, tx_busy}, 32'd0);
        wait_idle();

        // All-zero and all-one payloads
        run_frame(16'h0000, 8'h00, 1'b0, 1'b0, -1);
        wait_idle();
        run_frame(16'hFFFF, 8'hFF, 1'b0, 1'b0, -1);
        wait_idle();

        // Random payloads
        repeat (3) begin
            rc = 16'($urandom);
            rd = 8'($urandom_range(0, 255));
            @(negedge clk);
            run_frame(rc, rd, 1'b0, 1'b0, -1);
            wait_idle();
        end

        // Back-to-back frames with tx_start held high
        @(negedge clk);
        run_frame(16'h1234, 8'hA5, 1'b1, 1'b0, -1);
        run_frame(16'h5A0F, 8'h3C, 1'b0, 1'b0, -1);
        wait_idle();

        // Reset during bit 10, three cycles
        @(negedge clk);
        bits = {~8'h5D, 8'h5D, 16'hC3A1};
        stop_k = 1 + LEAD_MARK + LEAD_SPACE + 2;
        for (int i = 0; i < 10; i++) stop_k += BIT_MARK + (bits[i] ? ONE_SPACE : ZERO_SPACE);
        run_frame(16'hC3A1, 8'h5D, 1'b0, 1'b0, stop_k);
        rst_n = 1'b0;
        #1;
        check("async reset outputs", {28'd0, tx_busy, tx_done, ir_base, ir_led}, 32'h2);
        repeat (3) begin
            @(negedge clk);
            check("held reset outputs", {28'd0, tx_busy, tx_done, ir_base, ir_led}, 32'h2);
        end
        rst_n = 1'b1;
        repeat (GAP_LEN + 5) begin
            @(negedge clk);
            check("post-reset idle, no done", {28'd0, tx_busy, tx_done, ir_base, ir_led}, 32'h2);
        end
        run_frame(16'h6B86, 8'h45, 1'b0, 1'b0, -1);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
